// File: rtl/jogo_pkg.sv
// Shared definitions for the sequence-guessing game: state codes seen by the
// display decoder and the length of the secret.
package jogo_pkg;

    localparam int NUM_DIGITOS = 6;

    typedef enum logic [3:0] {
        INICIAL         = 4'd0,
        CERTO1_ERRO0    = 4'd1,
        CERTO2_ERRO0    = 4'd2,
        CERTO3_ERRO0    = 4'd3,
        CERTO4_ERRO0    = 4'd4,
        CERTO5_ERRO0    = 4'd5,
        SUCESSO_TOTAL   = 4'd6,
        CERTO0_ERRO1    = 4'd7,
        CERTO1_ERRO1    = 4'd8,
        CERTO2_ERRO1    = 4'd9,
        CERTO3_ERRO1    = 4'd10,
        CERTO4_ERRO1    = 4'd11,
        CERTO5_ERRO1    = 4'd12,
        SUCESSO_PARCIAL = 4'd13,
        FALHA           = 4'd14
    } estado_t;

endpackage

// File: rtl/borda_subida.sv
// Rising-edge detector: pulse is high in the cycle where in is 1 and the
// previous sample was 0. Reset clears the history so a held input re-triggers.
module borda_subida (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic r_anterior;

    always_ff @(posedge clk) begin
        if (reset) r_anterior <= 1'b0;
        else       r_anterior <= in;
    end

    assign pulse = in & ~r_anterior;

endmodule

// File: rtl/jogo_fsm.sv
// Game controller: checks confirmed digits against a six-digit BCD secret,
// allows one mistake, and forces failure after a period of inactivity.
module jogo_fsm
    import jogo_pkg::*;
#(
    parameter logic [23:0] SEGREDO        = 24'h654321,
    parameter int          TIMEOUT_CICLOS = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digito,
    input  logic       confirma,
    input  logic       inicia,
    output logic [3:0] estado,
    output logic [3:0] entrada,
    output logic       fim,
    output logic       invalido
);

    localparam int            CW       = $clog2(TIMEOUT_CICLOS);
    localparam logic [CW-1:0] CONT_MAX = CW'(TIMEOUT_CICLOS - 1);

    estado_t       r_estado, w_prox;
    logic [3:0]    r_entrada, w_entrada;
    logic          r_invalido, w_invalido;
    logic [CW-1:0] r_cont, w_cont;

    logic          w_borda;
    logic [3:0]    w_cod;
    logic [3:0]    w_idx4;
    logic [2:0]    w_n;
    logic [3:0]    w_dig_secreto;
    logic          w_aceita, w_jogando, w_erro1, w_ilegal;
    logic          w_tentativa, w_acerto;

    borda_subida u_borda (
        .clk   (clk),
        .reset (reset),
        .in    (confirma),
        .pulse (w_borda)
    );

    assign w_cod = r_estado;

    // Classify the current state; N is the index of the secret digit under test.
    always_comb begin
        w_aceita  = 1'b0;
        w_jogando = 1'b0;
        w_erro1   = 1'b0;
        w_ilegal  = 1'b0;
        w_idx4    = 4'd0;
        case (r_estado)
            INICIAL: w_aceita = 1'b1;
            CERTO1_ERRO0, CERTO2_ERRO0, CERTO3_ERRO0, CERTO4_ERRO0, CERTO5_ERRO0: begin
                w_aceita  = 1'b1;
                w_jogando = 1'b1;
                w_idx4    = w_cod;
            end
            CERTO0_ERRO1, CERTO1_ERRO1, CERTO2_ERRO1, CERTO3_ERRO1, CERTO4_ERRO1,
            CERTO5_ERRO1: begin
                w_aceita  = 1'b1;
                w_jogando = 1'b1;
                w_erro1   = 1'b1;
                w_idx4    = w_cod - 4'd7;
            end
            SUCESSO_TOTAL, SUCESSO_PARCIAL, FALHA: ;
            default: w_ilegal = 1'b1;
        endcase
    end

    assign w_n           = w_idx4[2:0];
    assign w_dig_secreto = SEGREDO[{w_n, 2'b00} +: 4];
    assign w_tentativa   = w_borda && w_aceita && (digito <= 4'd9);
    assign w_acerto      = (digito == w_dig_secreto);

    always_comb begin
        w_prox     = r_estado;
        w_entrada  = r_entrada;
        w_invalido = w_borda && (digito > 4'd9);
        w_cont     = w_jogando ? r_cont + 1'b1 : '0;
        if (inicia) begin
            w_prox     = INICIAL;
            w_entrada  = 4'd0;
            w_invalido = 1'b0;
        end else if (w_ilegal) begin
            w_prox = INICIAL;
        end else if (w_tentativa) begin
            w_entrada = digito;
            w_cont    = '0;
            if (w_acerto) begin
                if (w_n == 3'(NUM_DIGITOS - 1))
                    w_prox = w_erro1 ? SUCESSO_PARCIAL : SUCESSO_TOTAL;
                else
                    w_prox = estado_t'(w_cod + 4'd1);
            end else begin
                w_prox = w_erro1 ? FALHA : estado_t'({1'b0, w_n} + 4'd7);
            end
        end else if (w_jogando && (r_cont == CONT_MAX)) begin
            w_prox = FALHA;
        end
        // Every state entry starts a fresh inactivity window.
        if (w_prox != r_estado) w_cont = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado   <= INICIAL;
            r_entrada  <= 4'd0;
            r_invalido <= 1'b0;
            r_cont     <= '0;
        end else begin
            r_estado   <= w_prox;
            r_entrada  <= w_entrada;
            r_invalido <= w_invalido;
            r_cont     <= w_cont;
        end
    end

    assign estado   = r_estado;
    assign entrada  = r_entrada;
    assign invalido = r_invalido;
    assign fim      = (r_estado == SUCESSO_TOTAL) || (r_estado == SUCESSO_PARCIAL) ||
                      (r_estado == FALHA);

endmodule

// File: tb/tb_jogo_fsm.sv
// Directed bench for jogo_fsm: full success, partial success, failure,
// invalid digits, held confirm, inactivity timeout and reset priority.
module tb_jogo_fsm;

    localparam int T = 12;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] digito;
    logic       confirma;
    logic       inicia;
    logic [3:0] estado;
    logic [3:0] entrada;
    logic       fim;
    logic       invalido;

    int n_checks = 0;
    int n_pass   = 0;

    jogo_fsm #(
        .SEGREDO        (24'h654321),
        .TIMEOUT_CICLOS (T)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .digito   (digito),
        .confirma (confirma),
        .inicia   (inicia),
        .estado   (estado),
        .entrada  (entrada),
        .fim      (fim),
        .invalido (invalido)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic confirm(input logic [3:0] d);
        digito   = d;
        confirma = 1'b1;
        tick();
        confirma = 1'b0;
        tick();
    endtask

    task automatic restart();
        inicia = 1'b1;
        tick();
        inicia = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seq_ok [6];
        logic [3:0] seq_p  [7];
        logic [3:0] exp_p  [7];
        seq_ok = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        seq_p  = '{4'd1, 4'd9, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        exp_p  = '{4'd1, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13};

        reset = 1'b1; digito = 4'd0; confirma = 1'b0; inicia = 1'b0;
        repeat (2) tick();
        check("rst_estado", 32'(estado), 0);
        check("rst_entrada", 32'(entrada), 0);
        check("rst_fim", 32'(fim), 0);
        check("rst_invalido", 32'(invalido), 0);
        reset = 1'b0;
        tick();

        // Full success 1..6
        for (int i = 0; i < 6; i++) begin
            confirm(seq_ok[i]);
            check("total_estado", 32'(estado), 32'(i + 1));
        end
        check("total_entrada", 32'(entrada), 6);
        check("total_fim", 32'(fim), 1);
        confirm(4'd1);
        check("total_hold", 32'(estado), 6);
        check("total_hold_entrada", 32'(entrada), 6);
        restart();
        check("inicia_estado", 32'(estado), 0);
        check("inicia_entrada", 32'(entrada), 0);
        check("inicia_fim", 32'(fim), 0);

        // Partial success with one wrong digit
        for (int i = 0; i < 7; i++) begin
            confirm(seq_p[i]);
            check("parcial_estado", 32'(estado), 32'(exp_p[i]));
        end
        check("parcial_fim", 32'(fim), 1);
        restart();

        // Two wrong digits -> FALHA, terminal holds
        confirm(4'd7);
        check("falha_e1", 32'(estado), 7);
        confirm(4'd0);
        check("falha_e2", 32'(estado), 14);
        check("falha_fim", 32'(fim), 1);
        confirm(4'd5);
        check("falha_hold", 32'(estado), 14);
        check("falha_hold_entrada", 32'(entrada), 0);
        restart();
        check("falha_inicia", 32'(estado), 0);

        // Invalid digit in state 3, then held confirm
        confirm(4'd1); confirm(4'd2); confirm(4'd3);
        check("inv_pre", 32'(estado), 3);
        digito = 4'd12; confirma = 1'b1;
        tick();
        check("inv_pulse", 32'(invalido), 1);
        check("inv_estado", 32'(estado), 3);
        check("inv_entrada", 32'(entrada), 3);
        confirma = 1'b0;
        tick();
        check("inv_pulse_end", 32'(invalido), 0);
        digito = 4'd4; confirma = 1'b1;
        tick();
        check("held_first", 32'(estado), 4);
        check("held_entrada", 32'(entrada), 4);
        repeat (9) tick();
        check("held_single", 32'(estado), 4);
        confirma = 1'b0;
        tick();
        check("held_release", 32'(estado), 4);
        restart();

        // Inactivity timeout: FALHA exactly T cycles after entering state 1
        digito = 4'd1; confirma = 1'b1;
        tick();
        check("to_enter", 32'(estado), 1);
        confirma = 1'b0;
        repeat (T - 1) tick();
        check("to_before", 32'(estado), 1);
        tick();
        check("to_expire", 32'(estado), 14);
        restart();

        // Attempt on the expiry cycle wins
        digito = 4'd1; confirma = 1'b1;
        tick();
        confirma = 1'b0;
        repeat (T - 1) tick();
        digito = 4'd2; confirma = 1'b1;
        tick();
        check("to_attempt_wins", 32'(estado), 2);
        confirma = 1'b0;
        tick();
        restart();

        // Reset beats inicia and a confirm edge; held confirm counts after reset
        confirm(4'd7); confirm(4'd1); confirm(4'd2); confirm(4'd3);
        check("rst_mid_pre", 32'(estado), 10);
        digito = 4'd4; reset = 1'b1; inicia = 1'b1; confirma = 1'b1;
        tick();
        check("rst_mid_estado", 32'(estado), 0);
        check("rst_mid_entrada", 32'(entrada), 0);
        check("rst_mid_fim", 32'(fim), 0);
        check("rst_mid_invalido", 32'(invalido), 0);
        reset = 1'b0; inicia = 1'b0;
        tick();
        check("post_rst_edge", 32'(estado), 7);
        check("post_rst_entrada", 32'(entrada), 4);
        confirma = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
